// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the FIR MAC sequencer slice: default datapath widths
// (matching the shared 16x16->39b MAC ALU), default tap count and the
// sequencer state encoding.
// -----------------------------------------------------------------------------
package fir_pkg;

    localparam int FIR_DW    = 16;  // sample / coefficient width (ALU X and B)
    localparam int FIR_ACC_W = 39;  // accumulator width (ALU y)
    localparam int FIR_TAPS  = 8;   // default number of filter taps
    localparam int FIR_AW    = 3;   // default tap index width, clog2(FIR_TAPS)

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,   // waiting for a sample, coefficient writes allowed
        S_CLEAR = 2'd1,   // one-cycle synchronous clear of the ALU accumulator
        S_MAC   = 2'd2,   // TAPS multiply-accumulate cycles
        S_OUT   = 2'd3    // result presented until the consumer takes it
    } fir_state_e;

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// -----------------------------------------------------------------------------
// fir_mac_sequencer_if
// Sample-in / result-out streaming handshakes of the FIR MAC sequencer.
//   in_valid  : source has a sample on in_data
//   in_ready  : sequencer can take a sample this cycle
//   in_data   : signed sample x[n]
//   out_valid : out_data holds a finished filter result
//   out_ready : consumer takes the result this cycle
//   out_data  : signed accumulator value y[n]
// Modport slave is the sequencer side, master is the source/consumer side.
// -----------------------------------------------------------------------------
interface fir_mac_sequencer_if #(
    parameter int DW    = 16,
    parameter int ACC_W = 39
) ();

    logic                    in_valid;
    logic                    in_ready;
    logic signed [DW-1:0]    in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_data;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

endinterface

// File: rtl/fir_delay_line.sv
// -----------------------------------------------------------------------------
// fir_delay_line
// TAPS x DW circular sample history with one write port and one
// combinational indexed read port. Asynchronous active-low clear zeroes the
// whole history, so taps not yet filled after reset read as 0.
// Ports:
//   clk    : clock, rising edge
//   R_n    : asynchronous active-low clear
//   we     : write strobe
//   waddr  : write slot
//   wdata  : sample to store
//   raddr  : read slot
//   rdata  : sample stored in raddr (combinational)
// -----------------------------------------------------------------------------
module fir_delay_line #(
    parameter int TAPS = 8,
    parameter int AW   = 3,
    parameter int DW   = 16
) (
    input  logic                 clk,
    input  logic                 R_n,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic signed [DW-1:0] wdata,
    input  logic [AW-1:0]        raddr,
    output logic signed [DW-1:0] rdata
);

    logic signed [DW-1:0] mem [TAPS];

    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            for (int i = 0; i < TAPS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fir_mac_sequencer.sv
// -----------------------------------------------------------------------------
// fir_mac_sequencer
// Drives the shared 16x16->39b MAC ALU (instantiated by the parent) to produce
// one FIR output per accepted sample: y[n] = sum_k coef[k]*x[n-k].
// Per sample: IDLE (accept) -> CLEAR (alu_r pulse) -> MAC (TAPS cycles)
// -> OUT (hold result until out_ready) -> IDLE.
// Ports:
//   clk        : clock, rising edge
//   R_n        : asynchronous active-low reset (aborts, clears history/coefs)
//   strm       : sample-in / result-out handshakes (slave modport)
//   coef_we    : coefficient write strobe, honoured only while idle
//   coef_addr  : coefficient index k
//   coef_data  : coefficient value
//   busy       : high in every state except IDLE
//   alu_x      : ALU X, sample operand (0 outside MAC so the ALU holds)
//   alu_b      : ALU B, coefficient operand (0 outside MAC)
//   alu_r      : ALU R, synchronous accumulator clear
//   alu_y      : ALU y, accumulator value
// -----------------------------------------------------------------------------
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int TAPS  = FIR_TAPS,
    parameter int AW    = FIR_AW,
    parameter int DW    = FIR_DW,
    parameter int ACC_W = FIR_ACC_W
) (
    input  logic                    clk,
    input  logic                    R_n,
    fir_mac_sequencer_if.slave      strm,
    input  logic                    coef_we,
    input  logic [AW-1:0]           coef_addr,
    input  logic signed [DW-1:0]    coef_data,
    output logic                    busy,
    output logic signed [DW-1:0]    alu_x,
    output logic signed [DW-1:0]    alu_b,
    output logic                    alu_r,
    input  logic signed [ACC_W-1:0] alu_y
);

    fir_state_e state, state_nx;

    logic [AW-1:0]        wr_ptr;   // slot the next sample goes into
    logic [AW-1:0]        newest;   // slot holding x[n] of the current sample
    logic [AW-1:0]        k;        // tap index during MAC
    logic [AW-1:0]        rd_idx;
    logic signed [DW-1:0] hist_rd;
    logic signed [DW-1:0] coef [TAPS];
    logic                 accept;

    // Increment modulo TAPS; works for any TAPS, not only powers of two.
    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
        if (p == AW'(TAPS - 1)) begin
            return '0;
        end
        return p + AW'(1);
    endfunction

    // (a - b) mod TAPS. When a < b the AW-bit sum TAPS + a - b is exact
    // because the true result is below TAPS.
    function automatic logic [AW-1:0] wrap_sub(input logic [AW-1:0] a,
                                               input logic [AW-1:0] b);
        if (a >= b) begin
            return a - b;
        end
        return AW'(TAPS) + a - b;
    endfunction

    assign accept = (state == S_IDLE) && strm.in_valid;

    fir_delay_line #(
        .TAPS (TAPS),
        .AW   (AW),
        .DW   (DW)
    ) u_delay_line (
        .clk   (clk),
        .R_n   (R_n),
        .we    (accept),
        .waddr (wr_ptr),
        .wdata (strm.in_data),
        .raddr (rd_idx),
        .rdata (hist_rd)
    );

    // Tap k multiplies the sample k steps older than the newest one.
    assign rd_idx = wrap_sub(newest, k);

    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            state  <= S_IDLE;
            wr_ptr <= '0;
            newest <= '0;
            k      <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                newest <= wr_ptr;
                wr_ptr <= wrap_inc(wr_ptr);
            end
            if (state == S_CLEAR) begin
                k <= '0;
            end else if (state == S_MAC) begin
                k <= wrap_inc(k);
            end
        end
    end

    // Coefficients can only change between samples so a result never mixes
    // old and new coefficient sets; writes while busy are dropped.
    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            for (int i = 0; i < TAPS; i++) begin
                coef[i] <= '0;
            end
        end else if (coef_we && (state == S_IDLE)) begin
            coef[coef_addr] <= coef_data;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (strm.in_valid)          state_nx = S_CLEAR;
            S_CLEAR:                             state_nx = S_MAC;
            S_MAC:   if (k == AW'(TAPS - 1))     state_nx = S_OUT;
            S_OUT:   if (strm.out_ready)         state_nx = S_IDLE;
            default:                             state_nx = S_IDLE;
        endcase
    end

    // The ALU accumulates on every edge without R, so both operands are
    // forced to zero outside MAC to keep its result frozen.
    assign alu_x = (state == S_MAC) ? hist_rd : '0;
    assign alu_b = (state == S_MAC) ? coef[k] : '0;
    assign alu_r = (state == S_CLEAR);

    assign busy           = (state != S_IDLE);
    assign strm.in_ready  = (state == S_IDLE);
    assign strm.out_valid = (state == S_OUT);
    assign strm.out_data  = (state == S_OUT) ? alu_y : '0;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fir_mac_sequencer
// Bench for fir_mac_sequencer with TAPS=4. Contains a behavioural model of the
// shared MAC ALU, a sample-history/coefficient reference filter and a
// scoreboard queue popped by an independent output monitor.
// -----------------------------------------------------------------------------
module tb_fir_mac_sequencer;
    import fir_pkg::*;

    localparam int TAPS  = 4;
    localparam int AW    = 2;
    localparam int DW    = 16;
    localparam int ACC_W = 39;

    logic clk = 1'b0;
    logic R_n = 1'b0;
    always #5 clk = ~clk;

    fir_mac_sequencer_if #(.DW(DW), .ACC_W(ACC_W)) strm ();

    logic                    coef_we;
    logic [AW-1:0]           coef_addr;
    logic signed [DW-1:0]    coef_data;
    logic                    busy;
    logic signed [DW-1:0]    alu_x;
    logic signed [DW-1:0]    alu_b;
    logic                    alu_r;
    logic signed [ACC_W-1:0] alu_y = '0;
    logic signed [ACC_W-1:0] prod;

    fir_mac_sequencer #(
        .TAPS  (TAPS),
        .AW    (AW),
        .DW    (DW),
        .ACC_W (ACC_W)
    ) dut (
        .clk       (clk),
        .R_n       (R_n),
        .strm      (strm),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .busy      (busy),
        .alu_x     (alu_x),
        .alu_b     (alu_b),
        .alu_r     (alu_r),
        .alu_y     (alu_y)
    );

    // Shared MAC ALU: clear on R, otherwise accumulate X*B every edge.
    assign prod = ACC_W'(alu_x) * ACC_W'(alu_b);
    always @(posedge clk) begin
        alu_y <= alu_r ? '0 : alu_y + prod;
    end

    int errors = 0;
    int checks = 0;
    int n_out  = 0;
    int or_mode = 0;   // 0: out_ready=1, 1: random, 2: held low

    logic signed [ACC_W-1:0] exp_q [$];
    logic signed [ACC_W-1:0] mon_exp;

    // Reference filter state
    int m_coef [TAPS];
    int m_hist [$];    // front = newest sample

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic signed [ACC_W-1:0] model_y();
        longint acc = 0;
        for (int i = 0; i < TAPS; i++) begin
            if (i < m_hist.size())
                acc += longint'(m_coef[i]) * longint'(m_hist[i]);
        end
        return acc[ACC_W-1:0];
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_hist.delete();
        for (int i = 0; i < TAPS; i++) m_coef[i] = 0;
    endtask

    // Output monitor: pops the scoreboard on every result handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (R_n && strm.out_valid && strm.out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 64'd1, 64'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("out_data", strm.out_data, mon_exp);
                end
            end
        end
    end

    // Consumer ready pattern, changed just after each rising edge.
    initial begin
        strm.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (or_mode)
                0:       strm.out_ready = 1'b1;
                1:       strm.out_ready = 1'($urandom_range(0, 1));
                default: strm.out_ready = 1'b0;
            endcase
        end
    end

    task automatic send_sample(input logic signed [DW-1:0] x);
        int guard = 0;
        @(negedge clk);
        strm.in_valid = 1'b1;
        strm.in_data  = x;
        while (!strm.in_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!strm.in_ready) begin
            check("accept_timeout", 64'd0, 64'd1);
            strm.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            m_hist.push_front(int'(x));
            if (m_hist.size() > TAPS) void'(m_hist.pop_back());
            exp_q.push_back(model_y());
            #1;
            strm.in_valid = 1'b0;
        end
    endtask

    task automatic write_coef(input int addr, input int val);
        int guard = 0;
        @(negedge clk);
        while (!strm.in_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!strm.in_ready) begin
            check("coef_idle_timeout", 64'd0, 64'd1);
        end else begin
            coef_we   = 1'b1;
            coef_addr = AW'(addr);
            coef_data = DW'(val);
            @(posedge clk);
            m_coef[addr] = int'(signed'(DW'(val)));
            #1;
            coef_we = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int guard = 0;
        do begin
            @(posedge clk);
            #2;
            guard++;
        end while (!(exp_q.size() == 0 && strm.in_ready) && guard < 600);
        if (!(exp_q.size() == 0 && strm.in_ready))
            check("drain_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        R_n = 1'b0;
        model_reset();
        @(negedge clk);
        R_n = 1'b1;
    endtask

    initial begin
        int n_before;
        int guard;
        logic signed [ACC_W-1:0] held;

        strm.in_valid = 1'b0;
        strm.in_data  = '0;
        coef_we       = 1'b0;
        coef_addr     = '0;
        coef_data     = '0;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", strm.in_ready, 1);
        check("rst_out_valid", strm.out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_alu_r", alu_r, 0);
        check("rst_alu_x", alu_x, 0);
        check("rst_alu_b", alu_b, 0);
        R_n = 1'b1;

        // Impulse response
        for (int i = 0; i < TAPS; i++) write_coef(i, i + 1);
        n_before = n_out;
        send_sample(1);
        for (int i = 0; i < 4; i++) send_sample(0);
        wait_drain();
        check("impulse_count", n_out - n_before, 5);

        // Latency and handshake timing of one sample
        send_sample(5);
        for (int c = 1; c <= TAPS + 2; c++) begin
            @(negedge clk);
            check($sformatf("lat_alu_r_c%0d", c), alu_r, (c == 1));
            check($sformatf("lat_in_ready_c%0d", c), strm.in_ready, 0);
            check($sformatf("lat_out_valid_c%0d", c), strm.out_valid, (c == TAPS + 2));
        end
        wait_drain();

        // Backpressure in OUT
        or_mode = 2;
        send_sample(-7);
        guard = 0;
        while (!strm.out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("bp_reach_out", strm.out_valid, 1);
        held = strm.out_data;
        repeat (5) begin
            @(negedge clk);
            check("bp_out_valid", strm.out_valid, 1);
            check("bp_out_data", strm.out_data, held);
            check("bp_in_ready", strm.in_ready, 0);
            check("bp_alu_idle", {alu_r, alu_x, alu_b}, 0);
        end
        or_mode = 0;
        wait_drain();

        // Delay-line wrap from a clean history
        do_reset();
        for (int i = 0; i < TAPS; i++) write_coef(i, 1);
        n_before = n_out;
        for (int i = 0; i < 9; i++) send_sample(2);
        wait_drain();
        check("wrap_count", n_out - n_before, 9);

        // Coefficient write during MAC is dropped
        send_sample(3);
        @(negedge clk);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = '0;
        coef_data = 16'sd100;
        check("coef_busy_state", busy, 1);
        @(posedge clk);
        #1;
        coef_we = 1'b0;
        wait_drain();
        send_sample(1);
        wait_drain();

        // Asynchronous reset in the middle of MAC
        send_sample(9);
        repeat (3) @(negedge clk);
        R_n = 1'b0;
        #1;
        check("arst_out_valid", strm.out_valid, 0);
        check("arst_in_ready", strm.in_ready, 1);
        check("arst_busy", busy, 0);
        model_reset();
        @(negedge clk);
        R_n = 1'b1;
        n_before = n_out;
        send_sample(1);
        for (int i = 0; i < 4; i++) send_sample(0);
        wait_drain();
        check("arst_impulse_count", n_out - n_before, 5);

        // Randomized traffic with random consumer backpressure
        or_mode = 1;
        for (int i = 0; i < TAPS; i++) write_coef(i, int'($urandom_range(0, 65535)));
        n_before = n_out;
        for (int s = 0; s < 40; s++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_sample(DW'($urandom));
            if (s % 10 == 9)
                write_coef(int'($urandom_range(0, TAPS - 1)), int'($urandom_range(0, 65535)));
        end
        wait_drain();
        check("rand_count", n_out - n_before, 40);
        or_mode = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
